// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID-stage operand/producer info in, bypass selects and stall info out
interface hazard_forward_unit_if #(
  parameter int AWIDTH = 5,
  parameter int SELW = 2,
  parameter int CNTW = 32
);
  logic id_valid;
  logic [AWIDTH-1:0] id_rs1_addr;
  logic [AWIDTH-1:0] id_rs2_addr;
  logic id_rs1_used;
  logic id_rs2_used;
  logic [AWIDTH-1:0] id_rd_addr;
  logic id_reg_we;
  logic id_is_load;
  logic flush;
  logic pipe_hold;
  logic [SELW-1:0] forward_a_sel;
  logic [SELW-1:0] forward_b_sel;
  logic stall;
  logic [CNTW-1:0] stall_cnt;
  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_reg_we, id_is_load, flush, pipe_hold,
    input  forward_a_sel, forward_b_sel, stall, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_reg_we, id_is_load, flush, pipe_hold,
    output forward_a_sel, forward_b_sel, stall, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: shadow pipeline of in-flight writes driving bypass selects and load-use stalls
module hazard_forward_unit #(
  parameter int NSTAGES = 3,
  parameter int LOAD_LAT = 2,
  parameter int AWIDTH = 5,
  parameter int CNTW = 32
) (
  input logic clk,
  input logic rst_n,
  hazard_forward_unit_if.slave bus
);
  localparam int SELW = $clog2(NSTAGES + 1);
  typedef struct packed {
    logic v;
    logic [AWIDTH-1:0] rd;
    logic we;
    logic ld;
  } entry_t;
  entry_t e [1:NSTAGES];
  logic [NSTAGES:1] m_a, m_b;
  logic [SELW-1:0] sel_a, sel_b;
  logic lu_a, lu_b, stall;
  logic [CNTW-1:0] cnt;
  for (genvar k = 1; k <= NSTAGES; k++) begin : g_m
    assign m_a[k] = bus.id_valid & bus.id_rs1_used & e[k].v & e[k].we & (e[k].rd == bus.id_rs1_addr) & (|bus.id_rs1_addr);
    assign m_b[k] = bus.id_valid & bus.id_rs2_used & e[k].v & e[k].we & (e[k].rd == bus.id_rs2_addr) & (|bus.id_rs2_addr);
  end
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    lu_a = 1'b0;
    lu_b = 1'b0;
    for (int k = NSTAGES; k >= 1; k--) begin
      sel_a = m_a[k] ? SELW'(k) : sel_a;
      lu_a = m_a[k] ? (e[k].ld && k < LOAD_LAT) : lu_a;
      sel_b = m_b[k] ? SELW'(k) : sel_b;
      lu_b = m_b[k] ? (e[k].ld && k < LOAD_LAT) : lu_b;
    end
  end
  assign stall = (lu_a | lu_b) & ~bus.flush & ~bus.pipe_hold;
  assign bus.forward_a_sel = sel_a;
  assign bus.forward_b_sel = sel_b;
  assign bus.stall = stall;
  assign bus.stall_cnt = cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= NSTAGES; k++) e[k] <= '0;
      cnt <= '0;
    end else begin
      cnt <= (stall && !(&cnt)) ? cnt + CNTW'(1) : cnt;
      if (!bus.pipe_hold) begin
        e[1] <= stall ? '0 : entry_t'({bus.id_valid & ~bus.flush, bus.id_rd_addr, bus.id_reg_we, bus.id_is_load});
        for (int k = 2; k <= NSTAGES; k++) e[k] <= e[k-1];
      end
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed + random stimulus scored against a queue-based producer model
module tb_hazard_forward_unit;
  localparam int NS = 3;
  localparam int LL = 2;
  localparam int CMAX = 15;
  typedef struct {
    bit rn, v, u1, u2, we, ld, fl, hd;
    bit [4:0] rs1, rs2, rd;
  } stim_t;
  typedef struct {
    string tag;
    bit [1:0] sa, sb;
    bit st;
    bit [3:0] cnt;
  } exp_t;
  typedef struct {
    bit v;
    bit [4:0] rd;
    bit we;
    bit ld;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  ent_t pipe[$];
  int mcnt = 0;
  hazard_forward_unit_if #(.AWIDTH(5), .SELW(2), .CNTW(4)) bus ();
  hazard_forward_unit #(.NSTAGES(NS), .LOAD_LAT(LL), .AWIDTH(5), .CNTW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic stim_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit we, bit ld,
                               bit fl = 0, bit hd = 0, bit rn = 1);
    stim_t s;
    s.v = v; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = u1; s.u2 = u2;
    s.rd = 5'(rd); s.we = we; s.ld = ld; s.fl = fl; s.hd = hd; s.rn = rn;
    return s;
  endfunction
  function automatic int youngest(bit [4:0] a, bit used, bit v);
    if (!v || !used || a == 0) return 0;
    foreach (pipe[i]) if (pipe[i].v && pipe[i].we && pipe[i].rd == a) return i + 1;
    return 0;
  endfunction
  function automatic bit not_ready(int k);
    return k > 0 && pipe[k-1].ld && k < LL;
  endfunction
  function automatic void clear_model();
    ent_t z;
    z = '{0, 0, 0, 0};
    pipe = {};
    repeat (NS) pipe.push_back(z);
    mcnt = 0;
  endfunction
  task automatic step(input stim_t s, input string tag, input bit chk = 1);
    exp_t x;
    ent_t n;
    int a, b;
    bit st;
    rst_n = s.rn;
    bus.id_valid = s.v; bus.id_rs1_addr = s.rs1; bus.id_rs2_addr = s.rs2;
    bus.id_rs1_used = s.u1; bus.id_rs2_used = s.u2; bus.id_rd_addr = s.rd;
    bus.id_reg_we = s.we; bus.id_is_load = s.ld; bus.flush = s.fl; bus.pipe_hold = s.hd;
    a = youngest(s.rs1, s.u1, s.v);
    b = youngest(s.rs2, s.u2, s.v);
    st = (not_ready(a) || not_ready(b)) && !s.fl && !s.hd;
    x.tag = tag; x.sa = 2'(a); x.sb = 2'(b); x.st = st; x.cnt = 4'(mcnt);
    if (chk) q.push_back(x);
    @(posedge clk);
    if (!s.rn) clear_model();
    else if (!s.hd) begin
      if (st && mcnt < CMAX) mcnt++;
      n = st ? '{0, 0, 0, 0} : '{s.v && !s.fl, s.rd, s.we, s.ld};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
    #1;
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (q.size() != 0) begin
      x = q.pop_front();
      n_cmp++;
      if ({bus.forward_a_sel, bus.forward_b_sel, bus.stall, bus.stall_cnt} !== {x.sa, x.sb, x.st, x.cnt}) begin
        n_bad++;
        $display("FAIL %s: got a=%0d b=%0d stall=%0d cnt=%0d, want a=%0d b=%0d stall=%0d cnt=%0d",
                 x.tag, bus.forward_a_sel, bus.forward_b_sel, bus.stall, bus.stall_cnt,
                 x.sa, x.sb, x.st, x.cnt);
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    stim_t r;
    clear_model();
    step(mk(1, 3, 4, 1, 1, 3, 1, 1, 0, 0, 0), "reset0", 0);
    step(mk(1, 5, 6, 1, 1, 5, 1, 1, 0, 0, 0), "reset1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), "post_reset");
    step(mk(1, 1, 2, 1, 1, 5, 1, 0), "alu_prod");
    step(mk(1, 5, 5, 1, 1, 6, 1, 0), "alu_chain");
    repeat (3) step(mk(1, 0, 0, 0, 0, 7, 1, 0), "x7_write");
    step(mk(1, 7, 1, 1, 1, 2, 1, 0), "young_sel1");
    repeat (3) step(mk(1, 0, 0, 0, 0, 7, 1, 0), "x7_write2");
    step(mk(1, 0, 0, 0, 0, 1, 1, 0), "unrelated");
    step(mk(1, 7, 2, 1, 1, 3, 1, 0), "young_sel2");
    step(mk(1, 1, 0, 1, 0, 8, 1, 1), "lw_x8");
    step(mk(1, 8, 0, 1, 1, 9, 1, 0), "load_use_stall");
    step(mk(1, 8, 0, 1, 1, 9, 1, 0), "load_use_sel2");
    step(mk(1, 0, 0, 0, 0, 0, 1, 0), "write_x0");
    step(mk(1, 0, 0, 1, 1, 4, 1, 0), "read_x0");
    step(mk(1, 0, 0, 0, 0, 3, 1, 1), "lw_x3");
    step(mk(1, 0, 3, 1, 0, 4, 1, 0), "rs2_unused");
    step(mk(1, 0, 0, 0, 0, 8, 1, 1), "lw_x8_h");
    repeat (3) step(mk(1, 8, 0, 1, 1, 9, 1, 0, 0, 1), "hold_frozen");
    step(mk(1, 8, 0, 1, 1, 9, 1, 0), "hold_release");
    step(mk(1, 8, 0, 1, 1, 9, 1, 0), "hold_done");
    step(mk(1, 0, 0, 0, 0, 8, 1, 1), "lw_x8_f");
    step(mk(1, 8, 8, 1, 1, 9, 1, 0, 1), "flush_wins");
    step(mk(1, 8, 0, 1, 1, 9, 1, 0), "after_flush");
    repeat (44) step(mk(1, 10, 0, 1, 0, 10, 1, 1), "saturate");
    step(mk(1, 10, 0, 1, 0, 10, 1, 1), "sat_hold");
    for (int i = 0; i < 400; i++) begin
      r = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);
      step(r, "random");
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
